// File: rtl/edge_to_level.sv
// Rebuilds a level from rise/down strobes. Accepted events are queued in a FIFO,
// and each one is replayed onto `a` only after the minimum dwell of the previous one.
//
// state | meaning
// IDLE  | counter is 0; pops the FIFO head into `a` if the FIFO is not empty
// HOLD  | counter > 0; `a` is held and counter counts down once per edge
module edge_to_level #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rise,
  input  logic                     down,
  input  logic [HOLD_W-1:0]        min_hold,
  output logic                     a,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     redundant,
  output logic                     conflict
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [HOLD_W-1:0] counter;
  logic              mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              tail_lvl;

  logic lone, is_conflict, is_redundant, full, push, pop;

  // Events are judged against the level that will hold once the queue drains,
  // not against the level currently on `a`.
  always_comb begin
    lone         = rise ^ down;
    is_conflict  = rise & down;
    is_redundant = lone && (rise == tail_lvl);
    full         = (count == CW'(DEPTH));
    push         = lone && !is_redundant && !full;
    pop          = (state == IDLE) && (count != '0);
  end

  assign busy = (count != '0) || (counter != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      a         <= 1'b0;
      tail_lvl  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      redundant <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      conflict  <= is_conflict;
      redundant <= is_redundant;
      overflow  <= lone && !is_redundant && full;

      if (push) begin
        mem[wr_ptr] <= rise;
        wr_ptr      <= wr_ptr + AW'(1);
        tail_lvl    <= rise;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            a       <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
            counter <= min_hold;
            state   <= (min_hold != '0) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          counter <= counter - HOLD_W'(1);
          if (counter == HOLD_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_edge_to_level.sv
// Bench for edge_to_level: directed scenarios plus a randomized run checked
// against a queue-based model of the pending-event list.
module tb_edge_to_level;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rise = 1'b0;
  logic              down = 1'b0;
  logic [HOLD_W-1:0] min_hold = '0;
  logic              a, busy, overflow, redundant, conflict;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;

  edge_to_level #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .rise(rise), .down(down), .min_hold(min_hold),
    .a(a), .busy(busy), .count(count),
    .overflow(overflow), .redundant(redundant), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Model: list of pending levels, current level, remaining dwell, flags.
  bit q[$];
  bit m_a;
  int m_hold;
  int m_loaded;
  bit [2:0] m_flags;   // {overflow, redundant, conflict}
  bit m_changed;

  task automatic model_step(input bit r, input bit d, input int mh, input bit rn);
    bit tail;
    bit pop_ok;
    int sz;
    m_changed = 1'b0;
    if (!rn) begin
      q.delete();
      m_a = 1'b0;
      m_hold = 0;
      m_flags = '0;
      return;
    end
    tail   = (q.size() != 0) ? q[q.size()-1] : m_a;
    sz     = q.size();
    pop_ok = (m_hold == 0) && (sz > 0);
    m_flags = '0;
    if (pop_ok) begin
      bit nv;
      nv = q.pop_front();
      m_changed = (nv != m_a);
      m_a = nv;
      m_hold = mh;
      m_loaded = mh;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    if (r && d) m_flags[0] = 1'b1;
    else if (r || d) begin
      if (r == tail) m_flags[1] = 1'b1;
      else if (sz == DEPTH) m_flags[2] = 1'b1;
      else q.push_back(r);
    end
  endtask

  task automatic cyc(input bit r, input bit d, input int mh, input bit rn);
    rise = r; down = d; min_hold = HOLD_W'(mh); rst_n = rn;
    @(posedge clk);
    model_step(r, d, mh, rn);
    #1;
    rise = 1'b0; down = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 5, 0);
    n_checks++;
    if ({a, count, busy} !== {1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state a=%0b count=%0d busy=%0b required 0/0/0", a, count, busy);
    end
    n_checks++;
    if ({overflow, redundant, conflict} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b required 000", {overflow, redundant, conflict});
    end
  endtask

  task automatic test_single_rise();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    n_checks++;
    if (a !== 1'b0 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_push a=%0b count=%0d required a=0 count=1", a, count);
    end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency a=%0b required 1", a);
    end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy busy=%0b required 0", busy);
    end
  endtask

  task automatic test_hold();
    int peak;
    bit exp_a;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 3, 1);
    peak = count;
    cyc(0, 1, 3, 1);
    if (count > peak) peak = count;
    n_checks++;
    if (a !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first a=%0b required 1", a);
    end
    for (int e = 3; e <= 7; e++) begin
      cyc(0, 0, 3, 1);
      if (count > peak) peak = count;
      exp_a = (e >= 6) ? 1'b0 : 1'b1;
      n_checks++;
      if (a !== exp_a) begin
        n_fail++;
        $display("FAIL hold_dwell edge=%0d a=%0b required %0b", e, a, exp_a);
      end
    end
    n_checks++;
    if (peak !== 1) begin
      n_fail++;
      $display("FAIL hold_peak count_peak=%0d required 1", peak);
    end
  endtask

  task automatic test_overflow();
    bit seq[5] = '{1, 0, 1, 0, 1};
    bit early_ov;
    int guard;
    cyc(0, 0, 0, 0);
    early_ov = 1'b0;
    foreach (seq[i]) begin
      cyc(seq[i], !seq[i], 10, 1);
      if (overflow) early_ov = 1'b1;
    end
    n_checks++;
    if (count !== 3'd4 || early_ov) begin
      n_fail++;
      $display("FAIL ovf_fill count=%0d early_ov=%0b required count=4 early_ov=0", count, early_ov);
    end
    cyc(0, 1, 10, 1);
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_pulse overflow=%0b count=%0d required 1/4", overflow, count);
    end
    // a rise now must be redundant, showing the dropped down left tail_lvl at 1
    cyc(1, 0, 10, 1);
    n_checks++;
    if ({overflow, redundant, conflict} !== 3'b010) begin
      n_fail++;
      $display("FAIL ovf_tail flags=%b required 010", {overflow, redundant, conflict});
    end
    guard = 0;
    while ((busy || q.size() != 0 || m_hold != 0) && guard < 200) begin
      cyc(0, 0, 10, 1);
      guard++;
      n_checks++;
      if (a !== m_a || count !== 3'(q.size())) begin
        n_fail++;
        $display("FAIL ovf_drain a=%0b count=%0d required a=%0b count=%0d", a, count, m_a, q.size());
      end
    end
    n_checks++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL ovf_timeout busy=%0b required 0 within 200 cycles", busy);
    end
  endtask

  task automatic test_flags();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    n_checks++;
    if ({overflow, redundant, conflict} !== 3'b010 || count !== 3'd0 || a !== 1'b0) begin
      n_fail++;
      $display("FAIL redundant flags=%b count=%0d a=%0b required 010/0/0", {overflow, redundant, conflict}, count, a);
    end
    cyc(0, 0, 0, 1);
    n_checks++;
    if ({overflow, redundant, conflict} !== 3'b000) begin
      n_fail++;
      $display("FAIL flag_width flags=%b required 000", {overflow, redundant, conflict});
    end
    cyc(1, 1, 0, 1);
    n_checks++;
    if ({overflow, redundant, conflict} !== 3'b001 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL conflict flags=%b count=%0d required 001/0", {overflow, redundant, conflict}, count);
    end
  endtask

  task automatic test_toggle();
    bit prev;
    cyc(0, 0, 0, 0);
    prev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bit lvl;
      lvl = (i % 2 == 0);
      if (i < 8) cyc(lvl, !lvl, 0, 1);
      else cyc(0, 0, 0, 1);
      n_checks++;
      if (count > 3'd1 || {overflow, redundant, conflict} !== 3'b000 || (i > 0 && a !== prev)) begin
        n_fail++;
        $display("FAIL toggle step=%0d a=%0b count=%0d flags=%b required a=%0b count<=1 flags=000",
                 i, a, count, {overflow, redundant, conflict}, prev);
      end
      prev = lvl;
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 20, 1);
    cyc(0, 1, 20, 1);
    cyc(1, 0, 20, 1);
    cyc(0, 1, 20, 1);
    n_checks++;
    if (count !== 3'd3 || a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup count=%0d a=%0b required 3/1", count, a);
    end
    cyc(1, 0, 20, 0);
    n_checks++;
    if ({a, count, busy, overflow, redundant, conflict} !== 8'b0) begin
      n_fail++;
      $display("FAIL mid_reset a=%0b count=%0d busy=%0b flags=%b required all 0",
               a, count, busy, {overflow, redundant, conflict});
    end
    cyc(1, 0, 2, 1);
    cyc(0, 0, 2, 1);
    n_checks++;
    if (a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_post a=%0b required 1", a);
    end
  endtask

  task automatic test_random();
    int cycle, last_change, last_mh;
    cyc(0, 0, 0, 0);
    cycle = 0; last_change = -1000; last_mh = 0;
    for (int i = 0; i < 800; i++) begin
      bit r, d, rn;
      int mh;
      r  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 99) != 0);
      mh = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      cyc(r, d, mh, rn);
      cycle++;
      n_checks++;
      if (a !== m_a || count !== 3'(q.size()) || busy !== (q.size() != 0 || m_hold != 0) ||
          {overflow, redundant, conflict} !== m_flags) begin
        n_fail++;
        $display("FAIL random cyc=%0d a=%0b count=%0d busy=%0b flags=%b required a=%0b count=%0d busy=%0b flags=%b",
                 cycle, a, count, busy, {overflow, redundant, conflict},
                 m_a, q.size(), (q.size() != 0 || m_hold != 0), m_flags);
      end
      if (!rn) last_change = -1000;
      else if (m_changed) begin
        n_checks++;
        if (cycle - last_change < last_mh + 1) begin
          n_fail++;
          $display("FAIL dwell cyc=%0d gap=%0d required >=%0d", cycle, cycle - last_change, last_mh + 1);
        end
        last_change = cycle;
        last_mh = m_loaded;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_hold();
    test_overflow();
    test_flags();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_to_level.md
EDGE_TO_LEVEL -- requirements
Module: edge_to_level

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-event FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter HOLD_W, default 8, meaning width of the minimum-dwell count.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rise  input  1  single-cycle strobe requesting an output 0->1 transition.
REQ-006 SHALL have port down  input  1  single-cycle strobe requesting an output 1->0 transition.
REQ-007 SHALL have port min_hold  input  HOLD_W  minimum extra cycles the output holds after each transition.
REQ-008 SHALL have port a  output  1  reconstructed level, registered.
REQ-009 SHALL have port busy  output  1  high while FIFO non-empty or dwell counter non-zero.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse: valid event dropped because FIFO full.
REQ-012 SHALL have port redundant  output  1  one-cycle pulse: event dropped because it requests the level already pending.
REQ-013 SHALL have port conflict  output  1  one-cycle pulse: rise and down sampled high together.

Function
REQ-014 SHALL track tail_lvl = level a will have after all queued events apply; tail_lvl updates only on accepted push.
REQ-015 SHALL, when rise=1 and down=1 at the same edge, push nothing and pulse conflict at the next edge.
REQ-016 SHALL treat a lone rise with tail_lvl=1, or a lone down with tail_lvl=0, as redundant: no push, pulse redundant.
REQ-017 SHALL, for a non-redundant lone event with count=DEPTH (before any same-edge pop), drop it and pulse overflow; no push and no tail_lvl change.
REQ-018 SHALL otherwise push the target level (1 for rise, 0 for down) into the FIFO and set tail_lvl to it.
REQ-019 SHALL hold overflow, redundant and conflict at 0 except on the single cycle following the offending edge; at most one flag pulses per event.
REQ-020 SHALL operate an output FSM with states IDLE (counter=0) and HOLD (counter>0).
REQ-021 SHALL, at an edge in IDLE with FIFO non-empty, pop the head entry, load it into a, and load counter with min_hold sampled at that edge.
REQ-022 SHALL, if loaded min_hold=0, remain in IDLE, allowing a pop on the very next edge.
REQ-023 SHALL, in HOLD, decrement counter by 1 per edge, never pop, and return to IDLE when counter reaches 0.
REQ-024 SHALL guarantee that after a changes at edge T, the next change of a occurs no earlier than edge T+min_hold+1.
REQ-025 SHALL, when push and pop occur at the same edge, change count by 0; a push into an empty FIFO is not poppable until the following edge.
REQ-026 SHALL give latency: strobe sampled at edge N into an empty FIFO in IDLE -> a updated at edge N+1.
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH with no entry loss or duplication.
REQ-028 SHALL ignore changes on min_hold except at the pop edge.
REQ-029 SHALL drive busy combinationally as (count!=0)||(counter!=0).

Reset
REQ-030 SHALL, when rst_n=0 at an edge, set a=0, tail_lvl=0, counter=0, FSM=IDLE, FIFO empty (count=0), overflow=redundant=conflict=0; strobes at that edge are discarded.
REQ-031 SHALL apply reset identically mid-HOLD or with a non-empty FIFO; queued events are lost; first post-reset non-redundant strobe behaves per REQ-026.

Verification
REQ-032 SHALL cover: after reset, min_hold=0, rise at edge 1 -> a=1 at edge 2, busy low by edge 3.
REQ-033 SHALL cover: min_hold=3, rise at edge 1, down at edge 2 -> a=1 at edge 2, a=0 at edge 6, count peaks at 1.
REQ-034 SHALL cover: min_hold=10, DEPTH=4, strobes rise,down,rise,down,rise on 5 consecutive edges -> one pop then 4 queued, fifth not dropped until count=4; a sixth down during hold -> overflow pulse, tail_lvl unchanged.
REQ-035 SHALL cover: a=0 idle, down strobe -> redundant pulse, count=0, a stays 0; rise&down same edge -> conflict pulse only.
REQ-036 SHALL cover: min_hold=0, 8 alternating strobes on consecutive edges -> a toggles every edge with 1-edge lag, count never exceeds 1, no flags (pointer wrap).
REQ-037 SHALL cover: rst_n=0 during HOLD with count=3 -> next edge a=0, count=0, busy=0, flags 0.
